// File: rtl/vga_sync_rx.sv
// ----------------------------------------------------------------------------
// vga_sync_rx
//   VGA timing receiver / checker. Sits at the sink end of an h_sync/v_sync/RGB
//   stream, locks onto the sync pattern, rebuilds pixel coordinates and
//   re-times the colour samples behind a data-enable. Malformed lines and
//   frames are flagged and counted.
//
// Ports
//   i_clk            pixel clock, one pixel per cycle
//   i_rst            asynchronous reset, active low
//   i_h_sync         incoming horizontal sync (polarity set by SYNC_LOW)
//   i_v_sync         incoming vertical sync   (polarity set by SYNC_LOW)
//   i_red/green/blue incoming pixel colour, 4 bits each
//   o_x_out/o_y_out  coordinates of the current output pixel (valid with o_de,
//                    held while o_de is low)
//   o_de             visible-pixel enable, only while locked
//   o_r/g/b_out      re-timed colour, forced to 0 while o_de is low
//   o_frame_start    one-cycle pulse together with o_de on pixel (0,0)
//   o_locked         timing locked
//   o_err            one-cycle pulse on any timing violation
//   o_err_cnt        violation count, saturating at 255
//
// Latency from pin sample to every output is 2 clocks.
// ----------------------------------------------------------------------------
module vga_sync_rx #(
    parameter int H_VIS       = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VIS       = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit SYNC_LOW    = 1'b1,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_h_sync,
    input  logic       i_v_sync,
    input  logic [3:0] i_red,
    input  logic [3:0] i_green,
    input  logic [3:0] i_blue,
    output logic [9:0] o_x_out,
    output logic [9:0] o_y_out,
    output logic       o_de,
    output logic [3:0] o_r_out,
    output logic [3:0] o_g_out,
    output logic [3:0] o_b_out,
    output logic       o_frame_start,
    output logic       o_locked,
    output logic       o_err,
    output logic [7:0] o_err_cnt
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] C_CNT_MAX = 10'd1023;
    localparam logic [9:0] C_HTOT_M1 = 10'(H_TOTAL - 1);
    localparam logic [9:0] C_VTOT    = 10'(V_TOTAL);
    localparam logic [9:0] C_HA0     = 10'(H_SYNC + H_BP);
    localparam logic [9:0] C_HA1     = 10'(H_SYNC + H_BP + H_VIS);
    localparam logic [9:0] C_VA0     = 10'(V_SYNC + V_BP);
    localparam logic [9:0] C_VA1     = 10'(V_SYNC + V_BP + V_VIS);
    localparam logic [2:0] C_LOCK    = 3'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_VERIFY = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Stage 1: pin capture. Syncs are normalised to active-high here, so
    // everything downstream is polarity independent.
    // ------------------------------------------------------------------
    logic       r_hs1, r_hs2, r_vs1, r_vs2;
    logic [3:0] r_red1, r_grn1, r_blu1;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_hs1  <= 1'b0;
            r_hs2  <= 1'b0;
            r_vs1  <= 1'b0;
            r_vs2  <= 1'b0;
            r_red1 <= '0;
            r_grn1 <= '0;
            r_blu1 <= '0;
        end else begin
            r_hs1  <= i_h_sync ^ SYNC_LOW;
            r_hs2  <= r_hs1;
            r_vs1  <= i_v_sync ^ SYNC_LOW;
            r_vs2  <= r_vs1;
            r_red1 <= i_red;
            r_grn1 <= i_green;
            r_blu1 <= i_blue;
        end
    end

    logic w_h_edge, w_v_edge;
    assign w_h_edge = r_hs1 & ~r_hs2;
    assign w_v_edge = r_vs1 & ~r_vs2;

    // ------------------------------------------------------------------
    // Timing counters. The w_* values belong to the sample currently held
    // in stage 1; the r_* copies are the values of the previous sample.
    // ------------------------------------------------------------------
    logic [9:0] r_hcnt, r_lcnt, r_line;
    logic       r_h_seen, r_v_seen;
    logic [9:0] w_hcnt, w_lcnt, w_line;

    always_comb begin
        w_hcnt = w_h_edge ? 10'd0 :
                 (r_hcnt == C_CNT_MAX) ? C_CNT_MAX : r_hcnt + 10'd1;
    end

    // lcnt counts h edges for the frame-length check; an h edge that
    // coincides with the v edge belongs to the new frame, so it seeds 1.
    always_comb begin
        w_lcnt = r_lcnt;
        if (w_v_edge)
            w_lcnt = {9'd0, w_h_edge};
        else if (w_h_edge && r_lcnt != C_CNT_MAX)
            w_lcnt = r_lcnt + 10'd1;
    end

    // Line index for the active window: the line that holds the v edge is
    // line 0 regardless of whether an h edge shares that cycle.
    always_comb begin
        w_line = r_line;
        if (w_v_edge)
            w_line = 10'd0;
        else if (w_h_edge && r_line != C_CNT_MAX)
            w_line = r_line + 10'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_hcnt   <= '0;
            r_lcnt   <= '0;
            r_line   <= '0;
            r_h_seen <= 1'b0;
            r_v_seen <= 1'b0;
        end else begin
            r_hcnt   <= w_hcnt;
            r_lcnt   <= w_lcnt;
            r_line   <= w_line;
            r_h_seen <= r_h_seen | w_h_edge;
            r_v_seen <= r_v_seen | w_v_edge;
        end
    end

    // ------------------------------------------------------------------
    // Violation detection. Line/frame lengths are only judged once a
    // previous edge exists, so a partial line or frame after reset is not
    // blamed. Saturation fires on the single cycle hcnt reaches the cap.
    // ------------------------------------------------------------------
    logic w_line_bad, w_frame_bad, w_hsat, w_viol;

    assign w_line_bad  = w_h_edge & r_h_seen & (r_hcnt != C_HTOT_M1);
    assign w_frame_bad = w_v_edge & r_v_seen & (r_lcnt != C_VTOT);
    assign w_hsat      = (w_hcnt == C_CNT_MAX) & (r_hcnt != C_CNT_MAX);
    assign w_viol      = w_line_bad | w_frame_bad | w_hsat;

    // ------------------------------------------------------------------
    // Lock FSM
    // ------------------------------------------------------------------
    state_t     r_state, w_state_nxt;
    logic [2:0] r_good, w_good_nxt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_SEARCH;
            r_good  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_good  <= w_good_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        case (r_state)
            S_SEARCH: begin
                if (w_v_edge) begin
                    w_state_nxt = S_VERIFY;
                    w_good_nxt  = '0;
                end
            end
            S_VERIFY: begin
                if (w_viol) begin
                    w_state_nxt = S_SEARCH;
                end else if (w_v_edge) begin
                    // a v edge without violation closes a good frame
                    w_good_nxt = r_good + 3'd1;
                    if (w_good_nxt == C_LOCK)
                        w_state_nxt = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (w_viol)
                    w_state_nxt = S_SEARCH;
            end
            default: begin
                w_state_nxt = S_SEARCH;
                w_good_nxt  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Active window and coordinates for the stage-1 sample
    // ------------------------------------------------------------------
    logic       w_active, w_de_nxt;
    logic [9:0] w_x, w_y;

    assign w_active = (w_hcnt >= C_HA0) && (w_hcnt < C_HA1) &&
                      (w_line >= C_VA0) && (w_line < C_VA1);
    assign w_de_nxt = w_active && (r_state == S_LOCKED);
    assign w_x      = w_hcnt - C_HA0;
    assign w_y      = w_line - C_VA0;

    // ------------------------------------------------------------------
    // Stage 2: output registers
    // ------------------------------------------------------------------
    logic       r_de, r_fs, r_err;
    logic [9:0] r_x, r_y;
    logic [3:0] r_ro, r_go, r_bo;
    logic [7:0] r_err_cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_de      <= 1'b0;
            r_fs      <= 1'b0;
            r_err     <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_ro      <= '0;
            r_go      <= '0;
            r_bo      <= '0;
            r_err_cnt <= '0;
        end else begin
            r_de  <= w_de_nxt;
            r_fs  <= w_de_nxt && (w_x == 10'd0) && (w_y == 10'd0);
            r_err <= w_viol;
            if (w_de_nxt) begin
                r_x <= w_x;
                r_y <= w_y;
            end
            r_ro <= w_de_nxt ? r_red1 : 4'd0;
            r_go <= w_de_nxt ? r_grn1 : 4'd0;
            r_bo <= w_de_nxt ? r_blu1 : 4'd0;
            if (w_viol && r_err_cnt != 8'hFF)
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign o_x_out       = r_x;
    assign o_y_out       = r_y;
    assign o_de          = r_de;
    assign o_r_out       = r_ro;
    assign o_g_out       = r_go;
    assign o_b_out       = r_bo;
    assign o_frame_start = r_fs;
    assign o_locked      = (r_state == S_LOCKED);
    assign o_err         = r_err;
    assign o_err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_vga_sync_rx.sv
// ----------------------------------------------------------------------------
// tb_vga_sync_rx
//   Directed bench for vga_sync_rx using a shrunken raster (16 x 8 total,
//   8 x 4 visible) so whole frames are cheap. Two instances share the stream:
//   u_dut0 with active-low syncs, u_dut1 with active-high syncs.
// ----------------------------------------------------------------------------
module tb_vga_sync_rx;

    localparam int HV = 8, HF = 2, HS = 3, HB = 3;
    localparam int VV = 4, VF = 1, VS = 1, VB = 2;
    localparam int HT  = HV + HF + HS + HB;   // 16
    localparam int HA0 = HS + HB;             // 6
    localparam int VA0 = VS + VB;             // 3

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       hs0 = 1'b1, vs0 = 1'b1, hs1 = 1'b0, vs1 = 1'b0;
    logic [3:0] red = '0, grn = '0, blu = '0;

    logic [9:0] x0, y0, x1, y1;
    logic       de0, fs0, lk0, er0, de1, fs1, lk1, er1;
    logic [3:0] r0, g0, b0, r1, g1, b1;
    logic [7:0] ec0, ec1;

    always #5 clk = ~clk;

    vga_sync_rx #(.H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                  .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                  .SYNC_LOW(1'b1), .LOCK_FRAMES(2)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_h_sync(hs0), .i_v_sync(vs0),
        .i_red(red), .i_green(grn), .i_blue(blu),
        .o_x_out(x0), .o_y_out(y0), .o_de(de0),
        .o_r_out(r0), .o_g_out(g0), .o_b_out(b0),
        .o_frame_start(fs0), .o_locked(lk0), .o_err(er0), .o_err_cnt(ec0));

    vga_sync_rx #(.H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                  .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                  .SYNC_LOW(1'b0), .LOCK_FRAMES(2)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_h_sync(hs1), .i_v_sync(vs1),
        .i_red(red), .i_green(grn), .i_blue(blu),
        .o_x_out(x1), .o_y_out(y1), .o_de(de1),
        .o_r_out(r1), .o_g_out(g1), .o_b_out(b1),
        .o_frame_start(fs1), .o_locked(lk1), .o_err(er1), .o_err_cnt(ec1));

    int n_chk = 0, n_bad = 0;
    int cyc = 0;
    int ve[$];
    int fs_pin = 0, hedge_pin = 0, rst_base = 0;
    int fs_cnt, fs_cyc, fs_x, fs_y, fs_r, de_cnt, rsum, gsum, bsum, leak;
    int err_pulses, err_cyc, lock_cyc, lock_rises;
    int fs1_cyc, fs1_x, fs1_y, lock1_cyc;
    logic plk0 = 1'b0, plk1 = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        fs_cnt = 0; fs_cyc = -1; fs_x = -1; fs_y = -1; fs_r = -1;
        de_cnt = 0; rsum = 0; gsum = 0; bsum = 0; leak = 0;
        err_pulses = 0; err_cyc = -1; lock_cyc = -1; lock_rises = 0;
        fs1_cyc = -1; fs1_x = -1; fs1_y = -1; lock1_cyc = -1;
    endtask

    // Drive one pixel, clock it in, then observe outputs 1 ns after the edge.
    // Outputs for the pixel driven at cycle n show up once cyc reaches n+2.
    task automatic step(input logic hs_a, input logic vs_a,
                        input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        hs0 = ~hs_a; vs0 = ~vs_a; hs1 = hs_a; vs1 = vs_a;
        red = r; grn = g; blu = b;
        @(posedge clk);
        #1;
        cyc++;
        if (fs0) begin fs_cnt++; fs_cyc = cyc; fs_x = x0; fs_y = y0; fs_r = r0; end
        if (de0) begin de_cnt++; rsum += r0; gsum += g0; bsum += b0; end
        else if ({r0, g0, b0} != 12'd0) leak++;
        if (er0) begin err_pulses++; err_cyc = cyc; end
        if (lk0 && !plk0) begin lock_cyc = cyc; lock_rises++; end
        plk0 = lk0;
        if (fs1) begin fs1_cyc = cyc; fs1_x = x1; fs1_y = y1; end
        if (lk1 && !plk1) lock1_cyc = cyc;
        plk1 = lk1;
    endtask

    task automatic rst_pulse();
        chk("pre_rst_locked", lk0, 1);
        chk("pre_rst_de", de0, 1);
        #3 rst = 1'b0;
        #1;
        chk("rst_locked", lk0, 0);
        chk("rst_de", de0, 0);
        chk("rst_err_cnt", ec0, 0);
        chk("rst_x", x0, 0);
        chk("rst_y", y0, 0);
        chk("rst_rgb", {r0, g0, b0}, 0);
        chk("rst_fs", fs0, 0);
        chk("rst_err", er0, 0);
        #2 rst = 1'b1;
        rst_base = ve.size();
    endtask

    // One frame of nl lines; short_l gets HT-1 pixels; rst_l pulses reset mid-line.
    task automatic frame(input int nl, input int short_l, input int rst_l);
        for (int l = 0; l < nl; l++) begin
            int len;
            len = (l == short_l) ? HT - 1 : HT;
            for (int h = 0; h < len; h++) begin
                logic act;
                logic [3:0] xv, yv;
                if (l == rst_l && h == 10) rst_pulse();
                if (l == 0 && h == 0) ve.push_back(cyc);
                if (l == VA0 && h == HA0) fs_pin = cyc;
                if (l == short_l + 1 && h == 0) hedge_pin = cyc;
                act = (h >= HA0) && (h < HA0 + HV) && (l >= VA0) && (l < VA0 + VV);
                xv = 4'(h - HA0);
                yv = 4'(l - VA0);
                step(h < HS, l < VS, act ? xv : 4'd0, act ? yv : 4'd0,
                     act ? 4'd15 - xv : 4'd0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_locked", lk0, 0);
        chk("reset_de", de0, 0);
        chk("reset_err_cnt", ec0, 0);
        chk("reset_x", x0, 0);
        chk("reset_fs", fs0, 0);
        chk("reset_locked_pos", lk1, 0);
        #3 rst = 1'b1;
        repeat (3) step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);

        // 1 + 4: clean stream, lock at 3rd v edge, coordinates, colour path
        clear_stats();
        ve.delete();
        repeat (4) frame(8, -1, -1);
        chk("lock_time", lock_cyc, ve[2] + 2);
        chk("fs_time", fs_cyc, fs_pin + 2);
        chk("fs_count", fs_cnt, 2);
        chk("fs_x", fs_x, 0);
        chk("fs_y", fs_y, 0);
        chk("fs_r", fs_r, 0);
        chk("de_count", de_cnt, 64);
        chk("red_sum", rsum, 224);
        chk("green_sum", gsum, 96);
        chk("blue_sum", bsum, 736);
        chk("rgb_leak", leak, 0);
        chk("x_hold", x0, 7);
        chk("y_hold", y0, 3);
        chk("clean_err_cnt", ec0, 0);
        chk("pos_lock_time", lock1_cyc, ve[2] + 2);
        chk("pos_fs_time", fs1_cyc, fs_pin + 2);
        chk("pos_fs_x", fs1_x, 0);
        chk("pos_fs_y", fs1_y, 0);

        // 2: one 15-pixel line
        clear_stats();
        frame(8, 4, -1);
        chk("short_err_time", err_cyc, hedge_pin + 2);
        chk("short_err_pulses", err_pulses, 1);
        chk("short_err_cnt", ec0, 1);
        chk("short_unlock", lk0, 0);
        frame(8, -1, -1);
        frame(8, -1, -1);
        chk("short_no_early_lock", lk0, 0);
        frame(8, -1, -1);
        chk("short_relock", lk0, 1);
        chk("short_err_cnt_stable", ec0, 1);

        // 3: h_sync missing for 1100 cycles
        clear_stats();
        repeat (1100) step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
        chk("gap_err_pulses", err_pulses, 1);
        chk("gap_err_cnt", ec0, 2);
        chk("gap_unlock", lk0, 0);
        repeat (3) frame(8, -1, -1);
        chk("gap_resume_err_cnt", ec0, 3);
        chk("gap_relock", lk0, 1);

        // 5: 300 frames one line short
        clear_stats();
        repeat (300) frame(7, -1, -1);
        frame(8, -1, -1);
        chk("bad_frame_pulses", err_pulses, 300);
        chk("bad_frame_err_sat", ec0, 255);
        chk("bad_frame_lock_rises", lock_rises, 0);
        chk("bad_frame_locked", lk0, 0);

        // 6: reset mid-frame while locked
        repeat (4) frame(8, -1, -1);
        clear_stats();
        frame(8, -1, 4);
        e0 = rst_base;
        repeat (3) frame(8, -1, -1);
        chk("rst_relock_time", lock_cyc, ve[e0 + 2] + 2);
        chk("rst_relock", lk0, 1);
        chk("rst_err_cnt_after", ec0, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
